// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-file control path: default widths,
// command op-codes and the initiator FSM state encoding.
package reg_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_FILL     = 3'd4,
        ST_RSP      = 3'd5
    } state_e;

endpackage

// File: rtl/reg_file_initiator.sv
// Single-command initiator for the register file's shared read/write port.
// Every register-file strobe and the response are computed one cycle ahead.
module reg_file_initiator
    import reg_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rf_read_en,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data
);

    // One past the last address: FILL stops when its pointer reaches this.
    localparam logic [ADDR_W:0] FILL_END = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]      WAIT_INIT = 2'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [DATA_W-1:0] cdata_q, cdata_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [1:0]        wait_q, wait_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    assign cmd_ready     = (state_q == ST_IDLE) && rst;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rf_read_en    = rd_en_q;
    assign rf_write_en   = wr_en_q;
    assign rf_addr       = addr_q;
    assign rf_write_data = wdata_q;

    // Next-state and next-cycle strobe/response decode.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        caddr_d     = caddr_q;
        cdata_d     = cdata_q;
        sum_d       = sum_q;
        wait_d      = wait_q;
        fill_d      = fill_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        addr_d      = '0;
        wdata_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    caddr_d = cmd_addr;
                    cdata_d = cmd_data;
                    addr_d  = cmd_addr;
                    case (cmd_op)
                        OP_READ, OP_ADD: begin
                            state_d = ST_RD_ISSUE;
                            rd_en_d = 1'b1;
                        end
                        OP_WRITE: begin
                            state_d = ST_WR_ISSUE;
                            wr_en_d = 1'b1;
                            wdata_d = cmd_data;
                        end
                        default: begin
                            state_d = ST_FILL;
                            wr_en_d = 1'b1;
                            wdata_d = cmd_data;
                            fill_d  = {1'b0, cmd_addr} + {{ADDR_W{1'b0}}, 1'b1};
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
                wait_d  = WAIT_INIT;
            end
            ST_RD_WAIT: begin
                if (wait_q == 2'd0) begin
                    if (op_q == OP_ADD) begin
                        state_d = ST_WR_ISSUE;
                        wr_en_d = 1'b1;
                        addr_d  = caddr_q;
                        wdata_d = rf_read_data + cdata_q;
                        sum_d   = rf_read_data + cdata_q;
                    end else begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rf_read_data;
                    end
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_WR_ISSUE: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = (op_q == OP_ADD) ? sum_q : '0;
            end
            ST_FILL: begin
                if (fill_q == FILL_END) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = DATA_W'(FILL_END - {1'b0, caddr_q});
                end else begin
                    wr_en_d = 1'b1;
                    addr_d  = fill_q[ADDR_W-1:0];
                    wdata_d = cdata_q;
                    fill_d  = fill_q + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                rsp_data_d  = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            caddr_q     <= '0;
            cdata_q     <= '0;
            sum_q       <= '0;
            wait_q      <= 2'd0;
            fill_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            caddr_q     <= caddr_d;
            cdata_q     <= cdata_d;
            sum_q       <= sum_d;
            wait_q      <= wait_d;
            fill_q      <= fill_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: doc/reg_file_initiator.md
# reg_file_initiator

Command-driven initiator for the 32-bit, 16-entry register file's single read/write port. It accepts one command at a time from a host over a valid/ready channel and drives the register file's read_en/write_en/addr/write_data strobes. It captures read_data after the file's read latency and returns exactly one response per command over a second valid/ready channel. It sits between host-side control logic and the register file, and is the only agent that strobes that port.

## Interface

- DATA_W, 32, register and data width
- ADDR_W, 4, register address width; file depth is 2^ADDR_W
- RD_LATENCY, 1, cycles from the rf_read_en cycle until rf_read_data is valid; legal range 1..3

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 READ, 01 WRITE, 10 ADD (read-modify-write), 11 FILL
- cmd_addr  in  ADDR_W  target or start address
- cmd_data  in  DATA_W  write data, addend or fill value
- rsp_valid  out  1  response available
- rsp_ready  in  1  host accepts response
- rsp_data  out  DATA_W  response payload
- rf_read_en  out  1  register-file read strobe
- rf_write_en  out  1  register-file write strobe
- rf_addr  out  ADDR_W  register-file address
- rf_write_data  out  DATA_W  register-file write data
- rf_read_data  in  DATA_W  register-file read data

## Operation

- FSM states:
  - IDLE
  - RD_ISSUE
  - RD_WAIT
  - WR_ISSUE
  - FILL
  - RSP
- cmd_ready = 1 only in IDLE while rst is high. Command fields are latched on cmd_valid && cmd_ready.
- READ: IDLE → RD_ISSUE → RD_WAIT (RD_LATENCY cycles) → RSP.
  - rsp_data = value captured from rf_read_data.
- WRITE: IDLE → WR_ISSUE → RSP.
  - rsp_data = 0.
- ADD: IDLE → RD_ISSUE → RD_WAIT → WR_ISSUE → RSP.
  - Writes back captured + cmd_data, truncated to DATA_W (carry discarded).
  - rsp_data = the written sum.
- FILL: IDLE → FILL → RSP.
  - Writes cmd_data to addresses cmd_addr .. 2^ADDR_W−1, one per cycle, ascending.
  - No wrap-around: with cmd_addr = 15 and ADDR_W = 4, exactly one write occurs.
  - rsp_data = number of writes, N = 2^ADDR_W − cmd_addr, zero-extended.
- RSP: rsp_valid and rsp_data are held stable until rsp_ready. On handshake the FSM returns to IDLE.
- Strobe rules:
  - rf_read_en and rf_write_en are never both high.
  - Each strobe is high for exactly one cycle per access.
  - rf_addr and rf_write_data are 0 whenever neither strobe is high.
- Illegal cmd_op values do not exist (2-bit full decode).

## Timing

- Reset (rst low at an edge): FSM → IDLE. The following outputs are 0:
  - rsp_valid, rsp_data
  - rf_read_en, rf_write_en, rf_addr, rf_write_data
  - cmd_ready (0 while rst is low)
- Reset mid-operation: the command is abandoned, no response is issued, and strobes are low from the next edge. Registers already written by a partial FILL keep their values.
- Accept cycle A (cmd_valid && cmd_ready):
  - READ: rf_read_en in A+1; capture at end of A+1+RD_LATENCY; rsp_valid from A+2+RD_LATENCY.
  - WRITE: rf_write_en in A+1; rsp_valid from A+2.
  - ADD: rf_read_en in A+1; rf_write_en in A+2+RD_LATENCY; rsp_valid from A+3+RD_LATENCY.
  - FILL: rf_write_en in A+1 .. A+N; rsp_valid from A+N+1.
- Response handshake in cycle R: rsp_valid is low in R+1 and cmd_ready is high in R+1. Minimum command spacing is therefore response latency + 1 cycle.
- cmd_valid asserted while busy is ignored. The host must hold it until cmd_ready.
- All outputs except cmd_ready are registered. cmd_ready is decoded from state and rst.

## Structure

- Shared package reg_ctrl_pkg holds:
  - op-code constants OP_READ, OP_WRITE, OP_ADD, OP_FILL
  - the FSM state enum
  - DATA_W/ADDR_W defaults, so the register file and its benches share them
- Single module. The RD_WAIT counter (2 bits) and the FILL address/count counter (ADDR_W+1 bits) are inline. No sub-module is warranted.

## Test plan

- Reset → rst low 2 cycles. Required: all outputs 0, cmd_ready 0. After rst goes high, cmd_ready = 1 and no strobes.
- Write then read back:
  - WRITE addr 3 data 0x43211234 → rf_write_en one cycle with rf_addr 3; rsp_data 0.
  - READ addr 3 → rsp_data 0x43211234, rsp_valid 3 cycles after accept (RD_LATENCY = 1).
- ADD wrap: register 5 = 0xFFFFFFF0; ADD addr 5 data 0x20 → writes 0x00000010; rsp_data 0x00000010; rsp_valid 4 cycles after accept.
- FILL boundaries:
  - FILL addr 12 data 0xA5A5A5A5 → 4 consecutive writes to 12..15; rsp_data 4; reads of 11 and 12 return the old value and 0xA5A5A5A5.
  - FILL addr 15 → exactly 1 write; rsp_data 1.
  - FILL addr 0 → 16 writes; rsp_data 16.
- Backpressure: hold rsp_ready low 5 cycles. Required: rsp_valid/rsp_data stable, cmd_ready low, a second cmd_valid ignored. Accept the second command only the cycle after the rsp handshake.
- Reset mid-FILL: FILL addr 0, drop rst after 6 writes. Required: no rsp_valid, strobes low next cycle, registers 0..5 filled, register 6 unchanged.
